// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline hazard/stall controller.
//   state_t          : controller FSM states (binary encoding)
//   TIMEOUT_CYC_DEF  : default memory-service timeout in cycles
//   ctl_t            : bundle of pipeline write enables and flush controls
//   pipe_ctl()       : priority resolution of stall/flush requests
// Optional feature macro used by pipe_ctrl: STALL_CNT_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DSERV  = 2'd1,
        ST_ISERV  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_CYC_DEF = 63;
    localparam int unsigned TMO_W           = 8;

    // Bit order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
        logic if_id_flush;
        logic id_ex_flush;
    } ctl_t;

    localparam ctl_t CTL_NORMAL = 7'b11111_00;
    localparam ctl_t CTL_FREEZE = 7'b00000_00;
    localparam ctl_t CTL_BRANCH = 7'b11111_11;
    localparam ctl_t CTL_LDUSE  = 7'b00111_01;
    localparam ctl_t CTL_IFETCH = 7'b01111_10;

    // Highest priority first: halted/data freeze, branch redirect,
    // load-use bubble, instruction-fetch hold, normal flow.
    // Service states only constrain the pipeline while mem_done is low;
    // the completion cycle falls through to the normal priority chain.
    function automatic ctl_t pipe_ctl(input state_t st,
                                      input logic   mem_done,
                                      input logic   branch_taken,
                                      input logic   load_use);
        ctl_t c;
        c = CTL_NORMAL;
        if (st == ST_HALTED || (st == ST_DSERV && !mem_done)) begin
            c = CTL_FREEZE;
        end else if (branch_taken) begin
            c = CTL_BRANCH;
        end else if (load_use) begin
            c = CTL_LDUSE;
        end else if (st == ST_ISERV && !mem_done) begin
            c = CTL_IFETCH;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_tmo.sv
// pipe_tmo: memory-service wait counter with timeout compare.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   clear   in  hold counter at zero (asserted outside a service)
//   inc     in  count one wait cycle
//   expired out this wait cycle is the TIMEOUT_CYC-th one
module pipe_tmo
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed wait cycles, so the current wait cycle is
    // number cnt_q+1; flag it when that reaches the limit.
    assign expired = inc && (cnt_q == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline stall/flush controller with a single
// memory-service port shared by instruction and data misses.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   imiss, dmiss             fetch / data miss, held until serviced
//   mem_done                 one-cycle service completion pulse
//   load_use, branch_taken   ID load-use hazard, EX taken branch
//   halt                     halt instruction at WB
//   mem_req, mem_sel         service request, requester (1 = data)
//   pc_wen .. mem_wb_wen     pipeline register write enables
//   if_id_flush, id_ex_flush bubble-insert controls
//   mem_err                  sticky service timeout
//   stall_cnt                PC-stall cycle count (STALL_CNT_EN only)
// Optional feature: define STALL_CNT_EN to add the saturating stall counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imiss,
    input  logic        dmiss,
    input  logic        mem_done,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        halt,
    output logic        mem_req,
    output logic        mem_sel,
    output logic        pc_wen,
    output logic        if_id_wen,
    output logic        id_ex_wen,
    output logic        ex_mem_wen,
    output logic        mem_wb_wen,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_err
`ifdef STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    state_t state_q;
    logic   mem_err_q;
    logic   serving;
    logic   tmo_expired;
    ctl_t   ctl;

    assign serving = (state_q == ST_DSERV) || (state_q == ST_ISERV);

    pipe_tmo #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (!serving),
        .inc     (serving && !mem_done),
        .expired (tmo_expired)
    );

    // Every service returns to IDLE, which guarantees the one-cycle
    // mem_req gap between back-to-back services.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dmiss) begin
                        state_q <= ST_DSERV;
                    end else if (imiss) begin
                        state_q <= ST_ISERV;
                    end else if (halt) begin
                        state_q <= ST_HALTED;
                    end
                end
                ST_DSERV, ST_ISERV: begin
                    if (mem_done) begin
                        state_q <= ST_IDLE;
                    end else if (tmo_expired) begin
                        state_q   <= ST_HALTED;
                        mem_err_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req = serving;
    assign mem_sel = (state_q == ST_DSERV);
    assign mem_err = mem_err_q;

    always_comb begin
        ctl = pipe_ctl(state_q, mem_done, branch_taken, load_use);
    end

    assign pc_wen      = ctl.pc;
    assign if_id_wen   = ctl.if_id;
    assign id_ex_wen   = ctl.id_ex;
    assign ex_mem_wen  = ctl.ex_mem;
    assign mem_wb_wen  = ctl.mem_wb;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_flush = ctl.id_ex_flush;

`ifdef STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!ctl.pc && state_q != ST_HALTED && stall_q != '1) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 63: maximum cycles a memory service may wait for mem_done before error; legal range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 imiss  in  1  instruction fetch miss, held high until serviced.
REQ-005 dmiss  in  1  data access miss in MEM stage, held high until serviced.
REQ-006 mem_done  in  1  single-cycle pulse: current memory service complete.
REQ-007 load_use  in  1  ID-stage load-use hazard detected.
REQ-008 branch_taken  in  1  EX-stage taken-branch redirect.
REQ-009 halt  in  1  halt instruction reached WB.
REQ-010 mem_req  out  1  memory service request.
REQ-011 mem_sel  out  1  requester: 0 instruction, 1 data; valid while mem_req=1.
REQ-012 pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen  out  1 each  pipeline register write enables.
REQ-013 if_id_flush, id_ex_flush  out  1 each  bubble-insert controls.
REQ-014 mem_err  out  1  sticky timeout error.
REQ-015 stall_cnt  out  16  stall cycle count (only when STALL_CNT_EN defined).

Function
REQ-016 FSM states IDLE, DSERV, ISERV, HALTED; state registered, one-hot or binary at implementer choice.
REQ-017 IDLE: dmiss -> DSERV; else imiss -> ISERV; else halt -> HALTED; else stay; dmiss wins over simultaneous imiss.
REQ-018 DSERV/ISERV: mem_done -> IDLE; mem_req low exactly one cycle before any next service.
REQ-019 mem_req=1 and mem_sel=(state==DSERV) combinationally from state; mem_req rises one cycle after miss first seen in IDLE.
REQ-020 mem_done while IDLE or HALTED ignored.
REQ-021 DSERV, mem_done=0: all five wen=0, flushes=0 (full freeze).
REQ-022 DSERV mem_done cycle: all wen=1 so loaded data is captured.
REQ-023 ISERV, mem_done=0: pc_wen=0, if_id_wen=1, if_id_flush=1, downstream wen=1.
REQ-024 branch_taken (not frozen): pc_wen=1, if_id_flush=1, id_ex_flush=1, overriding load_use and ISERV PC hold; ISERV continues until mem_done.
REQ-025 load_use (no branch, not frozen): pc_wen=0, if_id_wen=0, id_ex_flush=1, others wen=1.
REQ-026 Priority: DSERV freeze > branch_taken > load_use > ISERV > normal (all wen=1, flushes=0).
REQ-027 8-bit wait counter clears on entry to DSERV/ISERV, increments each wait cycle; reaching TIMEOUT_CYC without mem_done sets mem_err and goes HALTED.
REQ-028 HALTED: all wen=0, flushes=0, mem_req=0; exit only by reset.

Reset
REQ-029 rst low: state IDLE, wait counter 0, mem_err 0, stall_cnt 0, mem_req 0; wen outputs follow IDLE combinational rules.
REQ-030 Reset mid-service abandons service immediately; no mem_req after rst release until a new miss.

Configuration
REQ-031 STALL_CNT_EN defined: stall_cnt increments each cycle pc_wen=0 outside HALTED, saturates at 16'hFFFF.
REQ-032 STALL_CNT_EN undefined: stall_cnt port and counter absent; all other behaviour identical.

Structure
REQ-033 Shared package pipe_pkg holds state encoding constants and TIMEOUT_CYC default.
REQ-034 Wait counter and compare in sub-module pipe_tmo (inputs clear, inc; output expired); rest in pipe_ctrl.

Verification
REQ-035 dmiss=1 in IDLE, mem_done at wait cycle 3 -> mem_req/mem_sel=1 from cycle 1, all wen=0 cycles 1-3, all wen=1 on done cycle, IDLE next.
REQ-036 imiss and dmiss same cycle -> DSERV first, mem_req low one cycle, then ISERV with mem_sel=0.
REQ-037 load_use and branch_taken same cycle in IDLE -> pc_wen=1, if_id_flush=1, id_ex_flush=1.
REQ-038 TIMEOUT_CYC=4, dmiss, no mem_done -> mem_err=1 after 4 wait cycles, HALTED, all wen=0; mem_done later ignored.
REQ-039 rst low during ISERV wait cycle 2 -> mem_req=0 same cycle, mem_err=0, stall_cnt=0; normal ops after release.
REQ-040 STALL_CNT_EN, 5 load_use cycles + 3-cycle ISERV wait -> stall_cnt=8.
